// File: rtl/mux_sel_stream.sv
// mux_sel_stream: N-to-1 word selector with a registered output stage and
// valid/ready handshakes on both sides. Direct-select mode emits one chosen
// word per request; scan mode snapshots every input and streams the words
// out in index order, one per beat, for the compare-swap stage.
module mux_sel_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_INPUTS = 8,
    parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] din,
    input  logic [SEL_WIDTH-1:0]             sel,
    input  logic                             mode,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic [SEL_WIDTH-1:0]             dout_idx,
    output logic                             dout_last,
    output logic                             dout_err,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [SEL_WIDTH-1:0]    r_cnt;
    logic [SEL_WIDTH-1:0]    w_cntNext;
    logic [DATA_WIDTH-1:0]   r_snap [NUM_INPUTS];

    logic [DATA_WIDTH-1:0]   r_dout;
    logic [SEL_WIDTH-1:0]    r_idx;
    logic                    r_last;
    logic                    r_err;
    logic                    r_valid;

    logic                    w_outFree;
    logic                    w_load;
    logic                    w_snapLoad;
    logic [DATA_WIDTH-1:0]   w_loadData;
    logic [SEL_WIDTH-1:0]    w_loadIdx;
    logic                    w_loadLast;
    logic                    w_loadErr;
    logic [DATA_WIDTH-1:0]   w_directWord;
    logic                    w_directHit;
    logic [DATA_WIDTH-1:0]   w_snapWord;

    // The output register can take a new beat when empty or being drained this cycle.
    assign w_outFree = !r_valid || out_ready;

    // Direct-select mux; an index with no matching word leaves the hit flag low.
    always_comb begin
        w_directWord = '0;
        w_directHit  = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (sel == SEL_WIDTH'(i)) begin
                w_directWord = din[i*DATA_WIDTH +: DATA_WIDTH];
                w_directHit  = 1'b1;
            end
        end
    end

    // Scan mux reading the snapshot at the current scan counter.
    always_comb begin
        w_snapWord = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (r_cnt == SEL_WIDTH'(i)) begin
                w_snapWord = r_snap[i];
            end
        end
    end

    // Next-state, request acceptance and output-register load decisions.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_load      = 1'b0;
        w_snapLoad  = 1'b0;
        w_loadData  = '0;
        w_loadIdx   = '0;
        w_loadLast  = 1'b0;
        w_loadErr   = 1'b0;
        in_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = w_outFree;
                if (in_valid && w_outFree) begin
                    if (!mode) begin
                        w_load     = 1'b1;
                        w_loadData = w_directWord;
                        w_loadIdx  = sel;
                        w_loadLast = 1'b1;
                        w_loadErr  = !w_directHit;
                    end else begin
                        w_snapLoad  = 1'b1;
                        w_cntNext   = '0;
                        w_stateNext = SCAN;
                    end
                end
            end
            SCAN: begin
                if (w_outFree) begin
                    w_load     = 1'b1;
                    w_loadData = w_snapWord;
                    w_loadIdx  = r_cnt;
                    w_loadLast = (r_cnt == SEL_WIDTH'(NUM_INPUTS - 1));
                    if (w_loadLast) begin
                        w_stateNext = IDLE;
                    end else begin
                        w_cntNext = r_cnt + SEL_WIDTH'(1);
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // FSM state and scan counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Snapshot array captures all inputs when a scan is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_snapLoad) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                r_snap[i] <= din[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Output register: load a new beat, or drop valid once the old beat transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_dout  <= w_loadData;
            r_idx   <= w_loadIdx;
            r_last  <= w_loadLast;
            r_err   <= w_loadErr;
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign dout      = r_dout;
    assign dout_idx  = r_idx;
    assign dout_last = r_last;
    assign dout_err  = r_err;
    assign out_valid = r_valid;
    assign busy      = (r_state == SCAN);

endmodule

// File: tb/tb_mux_sel_stream.sv
// tb_mux_sel_stream: directed test of mux_sel_stream covering reset, direct
// select streaming, backpressure, scan with input changes, scan stall, reset
// abort mid-scan, and out-of-range select on a 6-input instance.
module tb_mux_sel_stream;

    logic          clk = 1'b0;
    logic          rst_n;

    logic [127:0]  din;
    logic [2:0]    sel;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   dout;
    logic [2:0]    dout_idx;
    logic          dout_last;
    logic          dout_err;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    logic [95:0]   din6;
    logic [2:0]    sel6;
    logic          mode6;
    logic          in_valid6;
    logic          in_ready6;
    logic [15:0]   dout6;
    logic [2:0]    dout_idx6;
    logic          dout_last6;
    logic          dout_err6;
    logic          out_valid6;
    logic          out_ready6;
    logic          busy6;

    int            errors = 0;
    int            checks = 0;

    mux_sel_stream #(.DATA_WIDTH(16), .NUM_INPUTS(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .dout(dout),
        .dout_idx(dout_idx), .dout_last(dout_last), .dout_err(dout_err),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    mux_sel_stream #(.DATA_WIDTH(16), .NUM_INPUTS(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .din(din6), .sel(sel6), .mode(mode6),
        .in_valid(in_valid6), .in_ready(in_ready6), .dout(dout6),
        .dout_idx(dout_idx6), .dout_last(dout_last6), .dout_err(dout_err6),
        .out_valid(out_valid6), .out_ready(out_ready6), .busy(busy6)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic m, input logic [2:0] s, input logic r);
        in_valid  = v;
        mode      = m;
        sel       = s;
        out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkBeat(input string tag, input logic [15:0] d, input logic [2:0] idx, input logic last);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_dout"}, 32'(dout), 32'(d));
        checkOutput({tag, "_idx"}, 32'(dout_idx), 32'(idx));
        checkOutput({tag, "_last"}, 32'(dout_last), 32'(last));
        checkOutput({tag, "_err"}, 32'(dout_err), 32'd0);
    endtask

    task automatic setBaseDin();
        for (int i = 0; i < 8; i++) din[i*16 +: 16] = 16'(16'h1000 + i);
    endtask

    // Directed test sequence.
    initial begin
        rst_n = 1'b0;
        setBaseDin();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 6; i++) din6[i*16 +: 16] = 16'(16'h2000 + i);
        sel6 = 3'd0; mode6 = 1'b0; in_valid6 = 1'b0; out_ready6 = 1'b1;

        // Reset state and release.
        tick();
        tick();
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_dout", 32'(dout), 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
        checkOutput("idle_valid", 32'(out_valid), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Direct-select streaming at full rate.
        applyStimulus(1'b1, 1'b0, 3'd3, 1'b1);
        tick();
        checkBeat("dir3", 16'h1003, 3'd3, 1'b1);
        sel = 3'd7;
        tick();
        checkBeat("dir7", 16'h1007, 3'd7, 1'b1);
        sel = 3'd0;
        tick();
        checkBeat("dir0", 16'h1000, 3'd0, 1'b1);
        in_valid = 1'b0;
        tick();
        checkOutput("dir_drain_valid", 32'(out_valid), 32'd0);

        // Backpressure holds the beat and blocks new requests.
        applyStimulus(1'b1, 1'b0, 3'd5, 1'b0);
        tick();
        sel = 3'd2;
        for (int k = 0; k < 4; k++) begin
            checkBeat("bp_hold", 16'h1005, 3'd5, 1'b1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        checkBeat("bp_hold", 16'h1005, 3'd5, 1'b1);
        applyStimulus(1'b0, 1'b0, 3'd2, 1'b1);
        #1;
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        checkOutput("bp_one_transfer", 32'(out_valid), 32'd0);

        // Scan with din overwritten after acceptance.
        applyStimulus(1'b1, 1'b1, 3'd4, 1'b1);
        tick();
        checkOutput("scan_busy_start", 32'(busy), 32'd1);
        checkOutput("scan_gap_valid", 32'(out_valid), 32'd0);
        checkOutput("scan_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        din = {128{1'b1}};
        for (int k = 0; k < 8; k++) begin
            tick();
            checkBeat("scan", 16'(16'h1000 + k), 3'(k), (k == 7));
            if (k < 7) checkOutput("scan_busy", 32'(busy), 32'd1);
            else begin
                checkOutput("scan_end_busy", 32'(busy), 32'd0);
                checkOutput("scan_end_in_ready", 32'(in_ready), 32'd1);
            end
        end
        tick();
        checkOutput("scan_done_valid", 32'(out_valid), 32'd0);
        setBaseDin();

        // Scan stalled at index 4.
        applyStimulus(1'b1, 1'b1, 3'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkBeat("stall_pre", 16'(16'h1000 + k), 3'(k), 1'b0);
        end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkBeat("stall_hold", 16'h1004, 3'd4, 1'b0);
            checkOutput("stall_busy", 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        for (int k = 5; k < 8; k++) begin
            tick();
            checkBeat("stall_post", 16'(16'h1000 + k), 3'(k), (k == 7));
        end
        tick();
        checkOutput("stall_done_valid", 32'(out_valid), 32'd0);

        // Reset aborts a scan at index 2.
        applyStimulus(1'b1, 1'b1, 3'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        checkBeat("abort_pre", 16'h1002, 3'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_dout", 32'(dout), 32'd0);
        checkOutput("abort_idx", 32'(dout_idx), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("abort_no_beat", 32'(out_valid), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 1'b0, 3'd6, 1'b1);
        tick();
        checkBeat("after_abort", 16'h1006, 3'd6, 1'b1);
        in_valid = 1'b0;
        tick();

        // Out-of-range select on the 6-input instance.
        in_valid6 = 1'b1;
        sel6 = 3'd7;
        tick();
        checkOutput("oor_valid", 32'(out_valid6), 32'd1);
        checkOutput("oor_dout", 32'(dout6), 32'd0);
        checkOutput("oor_err", 32'(dout_err6), 32'd1);
        checkOutput("oor_idx", 32'(dout_idx6), 32'd7);
        checkOutput("oor_last", 32'(dout_last6), 32'd1);
        sel6 = 3'd5;
        tick();
        checkOutput("inr_dout", 32'(dout6), 32'h2005);
        checkOutput("inr_err", 32'(dout_err6), 32'd0);
        in_valid6 = 1'b0;
        tick();
        checkOutput("inr_drain", 32'(out_valid6), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_sel_stream.md
Name: mux_sel_stream

Overview:
- Parametrised N-to-1 word selector with a registered output and valid/ready handshakes on both sides.
- Successor to the fixed 4-input combinational selector in the bubble-sort top-down datapath.
- Two modes:
  - Direct-select: one chosen word per transaction.
  - Scan: snapshots all N inputs and streams them out in index order, feeding the compare-swap stage one element per beat.

Parameters:
- DATA_WIDTH, 16, width of each data word.
- NUM_INPUTS, 8, number of input words; legal range 2..64.
- SEL_WIDTH, $clog2(NUM_INPUTS), width of select and index fields (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  NUM_INPUTS*DATA_WIDTH  flattened inputs; word i = din[i*DATA_WIDTH +: DATA_WIDTH].
- sel  input  SEL_WIDTH  word index used in direct-select mode.
- mode  input  1  0 = direct-select, 1 = scan; sampled only on an accepted request.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- dout  output  DATA_WIDTH  selected word (registered).
- dout_idx  output  SEL_WIDTH  index of the word on dout.
- dout_last  output  1  final beat of a scan; also 1 on every direct-select beat.
- dout_err  output  1  beat came from an out-of-range sel.
- out_valid  output  1  dout/dout_idx/dout_last/dout_err valid.
- out_ready  input  1  downstream accepts the beat.
- busy  output  1  scan in progress.

Behaviour:
- Reset (rst_n low, asynchronous):
  - dout, dout_idx, dout_last, dout_err, out_valid, busy all 0.
  - FSM to IDLE; scan counter 0; snapshot registers 0.
  - Reset mid-scan aborts the scan immediately; no further beats are emitted.
- Definitions:
  - Accept = in_valid && in_ready.
  - Transfer = out_valid && out_ready.
  - Output register is free when !out_valid || out_ready.
- FSM states: IDLE, SCAN.
- IDLE:
  - in_ready = output register free (combinational).
  - Accept with mode=0:
    - Next cycle dout = word[sel], dout_idx = sel, dout_last = 1, out_valid = 1.
    - Latency is 1 cycle; throughput is 1 beat/cycle when out_ready stays high.
  - sel >= NUM_INPUTS (only possible when NUM_INPUTS is not a power of 2): dout = 0, dout_err = 1, all other fields as normal. Otherwise dout_err = 0.
  - Accept with mode=1:
    - Copy all NUM_INPUTS words into the snapshot array; counter = 0; go to SCAN.
    - busy = 1 from the next cycle.
    - sel is ignored.
- SCAN:
  - in_ready = 0; in_valid is ignored.
  - Whenever the output register is free, load snapshot[counter]: dout_idx = counter, dout_err = 0, dout_last = (counter == NUM_INPUTS-1), out_valid = 1. Then increment counter.
  - After the last word is loaded, go to IDLE and clear busy.
  - in_ready may rise in the same cycle that the last beat transfers (output register free).
  - First scan beat appears 1 cycle after the load cycle (2 cycles after Accept); thereafter 1 beat/cycle with out_ready held high.
  - Changes to din during SCAN do not affect emitted data.
- Backpressure:
  - While out_valid=1 and out_ready=0, dout, dout_idx, dout_last and dout_err hold stable.
  - The counter does not advance.
- Simultaneous events:
  - Transfer and Accept in the same cycle: the new beat replaces the old one with no bubble.
  - out_valid drops only when a Transfer occurs with no new load in that cycle.
- No combinational path from in_valid to out_valid.
- in_ready depends on out_ready combinationally.

Test Plan:
- Reset/idle: assert rst_n=0 mid-cycle -> all outputs 0 asynchronously. Release -> in_ready=1, out_valid=0, busy=0.
- Direct-select streaming: NUM_INPUTS=8, word i = 16'h1000+i, out_ready=1; sel = 3, 7, 0 on consecutive cycles -> dout = 1003, 1007, 1000 on the next 3 cycles; dout_last=1, dout_err=0 each beat.
- Backpressure: sel=5 accepted, out_ready=0 for 4 cycles -> dout=1005 held stable and in_ready=0. Release out_ready -> one transfer only.
- Scan with din change: mode=1 accepted, then din changed to all 16'hFFFF, out_ready=1 -> 8 beats 1000..1007, dout_idx 0..7, dout_last only on idx 7, busy high throughout. in_ready=1 on the cycle of the last transfer.
- Scan stall and reset abort: during scan, drop out_ready at idx 4 for 3 cycles -> idx 4 held, then 5 follows. Start a second scan and pull rst_n low at idx 2 -> out_valid=0, busy=0; next request accepted normally.
- Out-of-range select: NUM_INPUTS=6, SEL_WIDTH=3, sel=7 -> dout=0, dout_err=1, dout_idx=7, out_valid=1 after 1 cycle.
